// File: rtl/spi_controller.sv
// SPI mode-0 write-frame controller: shifts {1'b1, addr[6:0], data[7:0]} MSB first on cs_n/sclk/copi.
// Optional SPI_CTRL_ADDR_CHECK_EN: requests with addr > 4 are rejected with a one-cycle err pulse.
module spi_controller #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [6:0] addr,
    input  logic [7:0] data,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       cs_n,
    output logic       sclk,
    output logic       copi
);
    typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, TAIL, GAP} state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t      state_q, state_d;
    logic [7:0]  div_q, div_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [15:0] frame_q, frame_d;
    logic        cs_n_q, cs_n_d;
    logic        sclk_q, sclk_d;
    logic        copi_q, copi_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        tick;
    logic        reject;
    logic        accept;

    assign tick = (div_q == DIV_LAST);

`ifdef SPI_CTRL_ADDR_CHECK_EN
    assign reject = start && (addr > 7'd4);
`else
    assign reject = 1'b0;
`endif
    assign accept = start && !reject;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        frame_d   = frame_q;
        cs_n_d    = cs_n_q;
        sclk_d    = sclk_q;
        copi_d    = copi_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    frame_d   = {1'b1, addr, data};
                    bit_cnt_d = 4'd15;
                    copi_d    = 1'b1;
                    cs_n_d    = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = SETUP;
                end else if (reject) begin
                    err_d = 1'b1;
                end
            end
            SETUP: begin
                if (tick) begin
                    sclk_d  = 1'b1;
                    state_d = HIGH;
                end
            end
            HIGH: begin
                // Falling edge: the next bit goes out here so it is stable over the following rise.
                if (tick) begin
                    sclk_d = 1'b0;
                    if (bit_cnt_q == 4'd0) begin
                        state_d = TAIL;
                    end else begin
                        bit_cnt_d = bit_cnt_q - 4'd1;
                        copi_d    = frame_q[bit_cnt_q - 4'd1];
                        state_d   = LOW;
                    end
                end
            end
            LOW: begin
                if (tick) begin
                    sclk_d  = 1'b1;
                    state_d = HIGH;
                end
            end
            TAIL: begin
                if (tick) begin
                    cs_n_d  = 1'b1;
                    copi_d  = 1'b0;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (tick) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Divider restarts from zero whenever a state is (re)entered and never runs in IDLE.
        if ((state_d != state_q) || (state_q == IDLE) || tick) begin
            div_d = 8'd0;
        end else begin
            div_d = div_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            div_q     <= 8'd0;
            bit_cnt_q <= 4'd0;
            cs_n_q    <= 1'b1;
            sclk_q    <= 1'b0;
            copi_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            bit_cnt_q <= bit_cnt_d;
            cs_n_q    <= cs_n_d;
            sclk_q    <= sclk_d;
            copi_q    <= copi_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // Shift data is only consumed while a frame is active, so it needs no reset.
    always_ff @(posedge clk) begin
        frame_q <= frame_d;
    end

    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;
    assign cs_n = cs_n_q;
    assign sclk = sclk_q;
    assign copi = copi_q;

endmodule

// File: tb/tb_spi_controller.sv
// Bench for spi_controller: two instances (CLK_DIV 4 and 2) checked every cycle against a timing-rule model.
// Honours SPI_CTRL_ADDR_CHECK_EN the same way as the design.
module tb_spi_controller;
    localparam int N0 = 4;
    localparam int N1 = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] start_i = '0;
    logic [6:0] addr_i [2];
    logic [7:0] data_i [2];
    logic [1:0] busy_o, done_o, err_o, cs_n_o, sclk_o, copi_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit armed = 1'b0;

    // Reference model: per DUT, whether a frame is running and edges elapsed since acceptance.
    bit          m_act   [2];
    int          m_e     [2];
    logic [15:0] m_frame [2];
    bit          m_err   [2];

    // Observed-waveform monitor.
    logic        prev_cs   [2];
    logic        prev_sclk [2];
    logic [15:0] shift_w   [2];
    logic [15:0] word_w    [2];
    int          nbits     [2];
    int          last_nbits[2];
    int          fall_cyc  [2];
    int          rise_cyc  [2];
    int          done_cyc  [2];
    int          done_cnt  [2];
    int          sclk_rises[2];
    int          rise_sclk_cyc [2];
    int          prev_rise_sclk[2];

    always #5 clk = ~clk;

    spi_controller #(.CLK_DIV(N0)) u_div4 (
        .clk(clk), .rst_n(rst_n), .start(start_i[0]), .addr(addr_i[0]), .data(data_i[0]),
        .busy(busy_o[0]), .done(done_o[0]), .err(err_o[0]),
        .cs_n(cs_n_o[0]), .sclk(sclk_o[0]), .copi(copi_o[0])
    );

    spi_controller #(.CLK_DIV(N1)) u_div2 (
        .clk(clk), .rst_n(rst_n), .start(start_i[1]), .addr(addr_i[1]), .data(data_i[1]),
        .busy(busy_o[1]), .done(done_o[1]), .err(err_o[1]),
        .cs_n(cs_n_o[1]), .sclk(sclk_o[1]), .copi(copi_o[1])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int ndiv(input int d);
        return (d == 0) ? N0 : N1;
    endfunction

    function automatic bit addr_ok(input logic [6:0] a);
`ifdef SPI_CTRL_ADDR_CHECK_EN
        return a <= 7'd4;
`else
        return 1'b1;
`endif
    endfunction

    // Expected {cs_n, sclk, copi, busy, done} e edges after the accepting edge, from the timing rules.
    function automatic logic [4:0] model_out(input bit act, input int e, input logic [15:0] f, input int n);
        int k;
        logic cs, sc, cp, bz, dn;
        if (!act) return 5'b10000;
        cs = (e >= 33 * n);
        sc = (e >= n) && (e < 32 * n) && (((e / n) % 2) == 1);
        k  = e / (2 * n);
        if (k > 15) k = 15;
        cp = (e < 33 * n) ? f[15 - k] : 1'b0;
        bz = (e < 34 * n);
        dn = (e == 34 * n);
        return {cs, sc, cp, bz, dn};
    endfunction

    // Model update at the edge, compare and monitor just after it.
    initial begin
        for (int d = 0; d < 2; d++) begin
            m_act[d] = 0; m_e[d] = 0; m_frame[d] = '0; m_err[d] = 0;
            prev_cs[d] = 1'b1; prev_sclk[d] = 1'b0; shift_w[d] = '0; word_w[d] = '0;
            nbits[d] = 0; last_nbits[d] = 0; fall_cyc[d] = -1; rise_cyc[d] = -1;
            done_cyc[d] = -1; done_cnt[d] = 0; sclk_rises[d] = 0;
            rise_sclk_cyc[d] = 0; prev_rise_sclk[d] = 0;
        end
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n) armed = 1'b1;
            for (int d = 0; d < 2; d++) begin
                m_err[d] = 1'b0;
                if (!rst_n) begin
                    m_act[d] = 1'b0;
                end else if (!m_act[d] || m_e[d] == 34 * ndiv(d)) begin
                    if (start_i[d] && addr_ok(addr_i[d])) begin
                        m_act[d]   = 1'b1;
                        m_e[d]     = 0;
                        m_frame[d] = {1'b1, addr_i[d], data_i[d]};
                    end else begin
                        m_act[d] = 1'b0;
                        m_err[d] = start_i[d];
                    end
                end else begin
                    m_e[d]++;
                end
            end
            #1;
            for (int d = 0; d < 2; d++) begin
                if (armed)
                    chk($sformatf("cycle%0d_div%0d", cyc, ndiv(d)),
                        {26'd0, cs_n_o[d], sclk_o[d], copi_o[d], busy_o[d], done_o[d], err_o[d]},
                        {26'd0, model_out(m_act[d], m_e[d], m_frame[d], ndiv(d)), m_err[d]});
                if (prev_cs[d] && !cs_n_o[d]) begin
                    fall_cyc[d] = cyc; shift_w[d] = '0; nbits[d] = 0;
                end
                if (!prev_sclk[d] && sclk_o[d]) begin
                    shift_w[d] = {shift_w[d][14:0], copi_o[d]};
                    nbits[d]++;
                    sclk_rises[d]++;
                    prev_rise_sclk[d] = rise_sclk_cyc[d];
                    rise_sclk_cyc[d]  = cyc;
                end
                if (!prev_cs[d] && cs_n_o[d]) begin
                    rise_cyc[d] = cyc; word_w[d] = shift_w[d]; last_nbits[d] = nbits[d];
                end
                if (done_o[d]) begin
                    done_cyc[d] = cyc; done_cnt[d]++;
                end
                prev_cs[d]   = cs_n_o[d];
                prev_sclk[d] = sclk_o[d];
            end
        end
    end

    task automatic issue(input int d, input logic [6:0] a, input logic [7:0] dt, output int t);
        @(negedge clk);
        start_i[d] = 1'b1; addr_i[d] = a; data_i[d] = dt;
        t = cyc + 1;
        @(negedge clk);
        start_i[d] = 1'b0;
    endtask

    task automatic wait_done(input int d, input string nm);
        int w;
        w = 0;
        while (!done_o[d] && w < 400) begin
            @(negedge clk);
            w++;
        end
        chk(nm, {31'd0, done_o[d]}, 32'd1);
    endtask

    initial begin
        int t0, t, dc, fc, sr;
        for (int d = 0; d < 2; d++) begin
            addr_i[d] = '0; data_i[d] = '0;
        end
        // Model pinned against hand-derived values for frame 0x82A5, N=4.
        chk("model_e0",   {27'd0, model_out(1, 0,   16'h82A5, 4)}, 32'b00110);
        chk("model_e4",   {27'd0, model_out(1, 4,   16'h82A5, 4)}, 32'b01110);
        chk("model_e8",   {27'd0, model_out(1, 8,   16'h82A5, 4)}, 32'b00010);
        chk("model_e132", {27'd0, model_out(1, 132, 16'h82A5, 4)}, 32'b10010);
        chk("model_e136", {27'd0, model_out(1, 136, 16'h82A5, 4)}, 32'b10001);

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        for (int d = 0; d < 2; d++)
            chk($sformatf("reset_state_div%0d", ndiv(d)),
                {26'd0, cs_n_o[d], sclk_o[d], copi_o[d], busy_o[d], done_o[d], err_o[d]}, 32'b100000);

        // Frame 0x82A5, then 0x803C requested by holding start through the done cycle.
        @(negedge clk);
        start_i[0] = 1'b1; addr_i[0] = 7'd2; data_i[0] = 8'hA5;
        t0 = cyc + 1;
        @(negedge clk);
        addr_i[0] = 7'd0; data_i[0] = 8'h3C;
        wait_done(0, "b2b_first_done_seen");
        chk("frame1_word",  {16'd0, word_w[0]}, 32'h82A5);
        chk("frame1_nrise", last_nbits[0], 16);
        chk("frame1_csfall", fall_cyc[0] - t0, 0);
        chk("frame1_csrise", rise_cyc[0] - t0, 132);
        chk("frame1_done",   done_cyc[0] - t0, 136);
        dc = done_cnt[0];
        @(negedge clk);
        start_i[0] = 1'b0;
        chk("frame2_start", fall_cyc[0] - t0, 137);
        repeat (3) begin
            repeat (20) @(negedge clk);
            start_i[0] = 1'b1; addr_i[0] = 7'd3; data_i[0] = 8'h77;
            @(negedge clk);
            start_i[0] = 1'b0;
        end
        wait_done(0, "b2b_second_done_seen");
        chk("frame2_word", {16'd0, word_w[0]}, 32'h803C);
        chk("frame2_done", done_cyc[0] - t0, 273);
        repeat (200) @(negedge clk);
        chk("busy_pulses_ignored", done_cnt[0] - dc, 1);

        // Reset in the middle of a frame.
        issue(0, 7'd1, 8'h55, t);
        while (cyc < t + 39) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midreset_outputs", {29'd0, cs_n_o[0], sclk_o[0], busy_o[0]}, 32'b100);
        dc = done_cnt[0];
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        chk("midreset_no_done", done_cnt[0] - dc, 0);
        chk("midreset_idle", {31'd0, busy_o[0]}, 32'd0);

        // CLK_DIV=2 boundary.
        issue(1, 7'd1, 8'h00, t);
        wait_done(1, "div2_done_seen");
        chk("div2_word", {16'd0, word_w[1]}, 32'h8100);
        chk("div2_done", done_cyc[1] - t, 68);
        chk("div2_sclk_period", rise_sclk_cyc[1] - prev_rise_sclk[1], 4);

`ifdef SPI_CTRL_ADDR_CHECK_EN
        fc = fall_cyc[0];
        sr = sclk_rises[0];
        issue(0, 7'd5, 8'h12, t);
        chk("reject_err", {30'd0, err_o[0], cs_n_o[0]}, 32'b11);
        @(negedge clk);
        chk("reject_err_one_cycle", {31'd0, err_o[0]}, 32'd0);
        repeat (30) @(negedge clk);
        chk("reject_no_cs", fall_cyc[0] - fc, 0);
        chk("reject_no_sclk", sclk_rises[0] - sr, 0);
        issue(0, 7'd4, 8'hFF, t);
        wait_done(0, "addr4_done_seen");
        chk("addr4_word", {16'd0, word_w[0]}, 32'h84FF);
`else
        fc = 0;
        sr = 0;
        issue(0, 7'd5, 8'h11, t);
        chk("addr5_no_err", {31'd0, err_o[0]}, 32'd0);
        wait_done(0, "addr5_done_seen");
        chk("addr5_word", {16'd0, word_w[0]}, 32'h8511);
        chk("addr5_done", done_cyc[0] - t + fc + sr, 136);
`endif

        // Randomised traffic on both instances, including occasional resets.
        repeat (4000) begin
            @(negedge clk);
            rst_n = ($urandom % 700) != 0;
            for (int d = 0; d < 2; d++) begin
                start_i[d] = ($urandom % 6) == 0;
                addr_i[d]  = ($urandom % 2) ? 7'($urandom_range(0, 6)) : 7'($urandom % 128);
                data_i[d]  = 8'($urandom);
            end
        end
        rst_n = 1'b1;
        start_i = '0;
        repeat (300) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/spi_controller.md
# spi_controller

SPI mode-0 controller that drives write frames to the chip's SPI peripheral register file. It serialises a 16-bit frame: bit 15 = write flag (always 1), bits 14:8 = 7-bit register address, bits 7:0 = data, MSB first. It sits on the controller/test side of the SPI link, generating `cs_n`, `sclk` and `copi` from the fast system clock through a start/busy/done handshake.

## Interface
- `CLK_DIV`, default 4: SPI half-period in `clk` cycles. Legal range is 2..255.
- `clk`, input, 1: system clock. All logic is on its rising edge.
- `rst_n`, input, 1: active-low reset, synchronous to `clk`.
- `start`, input, 1: request a write. Sampled only when `busy`=0.
- `addr`, input, 7: register address. Latched when `start` is accepted.
- `data`, input, 8: write data. Latched when `start` is accepted.
- `busy`, output, 1: transaction in progress.
- `done`, output, 1: one-cycle pulse when the frame is complete.
- `err`, output, 1: one-cycle pulse when a request is rejected (see Configuration).
- `cs_n`, output, 1: active-low chip select.
- `sclk`, output, 1: SPI clock. Idles low.
- `copi`, output, 1: serial data out.

## Operation
- All outputs are registered.
- Reset values: `cs_n`=1, `sclk`=0, `copi`=0, `busy`=0, `done`=0, `err`=0. The FSM goes to IDLE and the divider and bit counter clear.
- Divider counter counts 0..CLK_DIV-1. A tick occurs when the count equals CLK_DIV-1; the counter then wraps to 0. The counter clears on every state entry.
- FSM states:
  - IDLE: if `start`=1, latch `frame`={1'b1, addr, data}, set `bit_cnt`=15, `copi`=frame[15], `cs_n`=0, `busy`=1, and go to SETUP.
  - SETUP: on tick, `sclk`=1, go to HIGH.
  - HIGH: on tick, `sclk`=0. If `bit_cnt`=0, go to TAIL. Otherwise decrement `bit_cnt`, drive `copi`=frame[bit_cnt-1], and go to LOW.
  - LOW: on tick, `sclk`=1, go to HIGH.
  - TAIL: on tick, `cs_n`=1, `copi`=0, go to GAP.
  - GAP: on tick, `busy`=0, `done`=1 for one cycle, go to IDLE.
- `copi` changes only on falling `sclk` edges, or at `cs_n` assertion for bit 15. It is stable across every rising `sclk` edge.
- Exactly 16 rising `sclk` edges occur per frame.
- `start` while `busy`=1 is ignored and not queued.
- `addr` and `data` may change freely after acceptance.
- `start` in the cycle where `done`=1 is accepted, because `busy` is already 0.
- Reset mid-frame: outputs take their reset values on the next edge. No `done` is produced and no partial frame resumes.

## Timing
- Let N = CLK_DIV, and let T be the edge that samples `start`=1 in IDLE.
- `cs_n` falls and `busy` rises after edge T. `copi` is valid with bit 15 from the same edge.
- Rising `sclk` edge k (k=1..16) occurs at edge T+(2k-1)N.
- Falling `sclk` edge k occurs at T+2kN. At that edge `copi` advances to the next bit (for k<16).
- `cs_n` rises at T+33N.
- `done`=1 and `busy`=0 at T+34N. Total latency is 34N cycles; back-to-back throughput is one frame per 34N cycles.
- Minimum `cs_n`-high gap between frames is N+1 cycles.

## Configuration
- Macro: `SPI_CTRL_ADDR_CHECK_EN`.
- When defined: a `start` with `addr`>4 in IDLE is rejected.
  - `err`=1 for one cycle after edge T.
  - `busy`, `cs_n`, `sclk` and `copi` do not change, and the FSM stays in IDLE.
  - Addresses 0..4 behave normally.
- When undefined: every address is transmitted and `err` is tied to 0.

## Test plan
- Reset, then hold `rst_n`=1 for 10 cycles -> `cs_n`=1, `sclk`=0, `copi`=0, `busy`=0, `done`=0, `err`=0.
- CLK_DIV=4, `start` with addr=2, data=0xA5 -> monitor sampling `copi` on 16 rising `sclk` edges reads 0x82A5.
  - `cs_n` rises at T+132.
  - `done` pulses at T+136.
- Back-to-back: second `start` (addr=0, data=0x3C) held high through the `done` cycle -> second frame 0x803C begins at T+137. `start` pulses during `busy` produce no extra frames.
- Reset asserted at T+40 mid-frame -> next edge `cs_n`=1, `sclk`=0, `busy`=0. No `done` pulse occurs.
- With `SPI_CTRL_ADDR_CHECK_EN` defined: `start` addr=5 -> `err` pulses 1 cycle, `cs_n` stays 1, no `sclk` edges. `start` addr=4, data=0xFF -> frame 0x84FF sent.
- CLK_DIV=2 boundary: addr=1, data=0x00 -> frame 0x8100, `done` at T+68, `sclk` period 4 cycles.
